// File: rtl/jesd_tx_pkg.sv
// Shared definitions for the JESD204 transmit link controller: FSM encoding,
// lane-mux codes and the SYNC~ resynchronisation threshold.
package jesd_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CGS       = 3'd1,
        ST_WAIT_LMFC = 3'd2,
        ST_ILA       = 3'd3,
        ST_DATA      = 3'd4
    } link_state_e;

    localparam logic [1:0] LANE_CGS  = 2'b00;
    localparam logic [1:0] LANE_ILA  = 2'b01;
    localparam logic [1:0] LANE_DATA = 2'b10;

    localparam int unsigned RESYNC_FRAMES = 5;
    localparam int unsigned RESYNC_OCTETS = 9;

    // SYNC~ low for this many octets means resync; anything shorter is an error report.
    function automatic logic [10:0] resync_threshold(input logic [7:0] f);
        return 11'(RESYNC_FRAMES) * ({3'b000, f} + 11'd1) + 11'(RESYNC_OCTETS);
    endfunction

endpackage

// File: rtl/lmfc_counter.sv
// Free-running octet/frame counters defining the local multiframe clock.
module lmfc_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_F,
    input  logic [4:0] i_K,
    output logic [7:0] o_octet_cnt,
    output logic [4:0] o_frame_cnt,
    output logic       o_lmfc
);

    logic [7:0] octet_q, octet_d;
    logic [4:0] frame_q, frame_d;
    logic       octet_wrap;

    // Wrap on >= so a run-time shrink of F or K cannot leave a counter stranded above its limit.
    always_comb begin
        octet_wrap = (octet_q >= i_F);
        octet_d    = octet_wrap ? 8'd0 : octet_q + 8'd1;
        frame_d    = frame_q;
        if (octet_wrap) begin
            frame_d = (frame_q >= i_K) ? 5'd0 : frame_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            octet_q <= 8'd0;
            frame_q <= 5'd0;
        end else begin
            octet_q <= octet_d;
            frame_q <= frame_d;
        end
    end

    assign o_octet_cnt = octet_q;
    assign o_frame_cnt = frame_q;
    assign o_lmfc      = (octet_q == 8'd0) && (frame_q == 5'd0);

endmodule

// File: rtl/tx_link_ctrl.sv
// JESD204 transmit link FSM: CGS -> LMFC-aligned ILA -> DATA, with SYNC~
// monitoring for resync requests and error reports while in DATA.
module tx_link_ctrl
    import jesd_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_link_en,
    input  logic       i_sync_n,
    input  logic [7:0] i_F,
    input  logic [4:0] i_K,
    input  logic       i_seq_end,
    output logic       o_seq_start,
    output logic [4:0] o_no_frame_de_assertion,
    output logic [1:0] o_state,
    output logic       o_link_up,
    output logic       o_lmfc,
    output logic       o_sync_req,
    output logic       o_err_report
);

    link_state_e state_q, state_d;
    logic        seen_low_q, seen_low_d;
    logic        sync_prev_q;
    logic [10:0] low_cnt_q, low_cnt_d;
    logic [4:0]  nfda_q, nfda_d;
    logic [7:0]  octet_cnt;
    logic [4:0]  frame_cnt;
    logic [10:0] low_plus;
    logic [10:0] threshold;

    lmfc_counter u_lmfc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_F         (i_F),
        .i_K         (i_K),
        .o_octet_cnt (octet_cnt),
        .o_frame_cnt (frame_cnt),
        .o_lmfc      (o_lmfc)
    );

    assign threshold = resync_threshold(i_F);
    assign low_plus  = (low_cnt_q == 11'h7FF) ? low_cnt_q : low_cnt_q + 11'd1;

    // Pulses are decided in the same cycle as the transition that causes them,
    // so the state change guarantees they never last two cycles.
    always_comb begin
        state_d      = state_q;
        seen_low_d   = seen_low_q;
        low_cnt_d    = low_cnt_q;
        nfda_d       = nfda_q;
        o_seq_start  = 1'b0;
        o_sync_req   = 1'b0;
        o_err_report = 1'b0;
        if (!i_link_en) begin
            state_d    = ST_IDLE;
            seen_low_d = 1'b0;
            low_cnt_d  = 11'd0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CGS;
                ST_CGS: begin
                    if (!i_sync_n) begin
                        seen_low_d = 1'b1;
                    end else if (!sync_prev_q && seen_low_q) begin
                        nfda_d     = frame_cnt;
                        seen_low_d = 1'b0;
                        state_d    = ST_WAIT_LMFC;
                    end
                end
                ST_WAIT_LMFC: begin
                    if (!i_sync_n) begin
                        state_d    = ST_CGS;
                        seen_low_d = 1'b1;
                    end else if (octet_cnt == i_F && frame_cnt == i_K) begin
                        o_seq_start = 1'b1;
                        state_d     = ST_ILA;
                    end
                end
                ST_ILA: begin
                    low_cnt_d = 11'd0;
                    if (!i_sync_n) begin
                        state_d    = ST_CGS;
                        seen_low_d = 1'b1;
                    end else if (i_seq_end) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!i_sync_n) begin
                        low_cnt_d = low_plus;
                        if (low_plus >= threshold) begin
                            o_sync_req = 1'b1;
                            state_d    = ST_CGS;
                            seen_low_d = 1'b1;
                            low_cnt_d  = 11'd0;
                        end
                    end else begin
                        o_err_report = (low_cnt_q != 11'd0) && (low_cnt_q < threshold);
                        low_cnt_d    = 11'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            seen_low_q  <= 1'b0;
            sync_prev_q <= 1'b1;
            low_cnt_q   <= 11'd0;
            nfda_q      <= 5'd0;
        end else begin
            state_q     <= state_d;
            seen_low_q  <= seen_low_d;
            sync_prev_q <= i_sync_n;
            low_cnt_q   <= low_cnt_d;
            nfda_q      <= nfda_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_ILA:  o_state = LANE_ILA;
            ST_DATA: o_state = LANE_DATA;
            default: o_state = LANE_CGS;
        endcase
    end

    assign o_link_up               = (state_q == ST_DATA);
    assign o_no_frame_de_assertion = nfda_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Directed bench for tx_link_ctrl with F=1, K=3 (8-octet multiframe, resync threshold 19).
module tb_tx_link_ctrl;

    logic       clk;
    logic       rst_n;
    logic       i_link_en;
    logic       i_sync_n;
    logic [7:0] i_F;
    logic [4:0] i_K;
    logic       i_seq_end;
    logic       o_seq_start;
    logic [4:0] o_no_frame_de_assertion;
    logic [1:0] o_state;
    logic       o_link_up;
    logic       o_lmfc;
    logic       o_sync_req;
    logic       o_err_report;

    tx_link_ctrl dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_link_en               (i_link_en),
        .i_sync_n                (i_sync_n),
        .i_F                     (i_F),
        .i_K                     (i_K),
        .i_seq_end               (i_seq_end),
        .o_seq_start             (o_seq_start),
        .o_no_frame_de_assertion (o_no_frame_de_assertion),
        .o_state                 (o_state),
        .o_link_up               (o_link_up),
        .o_lmfc                  (o_lmfc),
        .o_sync_req              (o_sync_req),
        .o_err_report            (o_err_report)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    typedef struct {
        int         n;
        logic       en;
        logic       sn;
        logic       se;
        logic [1:0] st;
        logic       lu;
        logic       ss;
        logic       sr;
        logic       er;
        logic [4:0] nf;
    } vec_t;

    vec_t vecs[$];
    int   tests_run;
    int   tests_failed;
    int   cyc;

    function automatic void add(input int n, input logic en, input logic sn, input logic se,
                                input logic [1:0] st, input logic lu, input logic ss,
                                input logic sr, input logic er, input logic [4:0] nf);
        vec_t v;
        v.n = n; v.en = en; v.sn = sn; v.se = se; v.st = st;
        v.lu = lu; v.ss = ss; v.sr = sr; v.er = er; v.nf = nf;
        vecs.push_back(v);
    endfunction

    function automatic logic [11:0] got_vec();
        return {o_state, o_link_up, o_lmfc, o_seq_start, o_sync_req, o_err_report,
                o_no_frame_de_assertion};
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = got_vec();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cyc%0d {state,up,lmfc,start,sreq,err,nfda} got %b want %b",
                     name, cyc, got, exp);
        end
    endtask

    // Called at posedge+1; drives, checks at the following negedge, then advances one edge.
    // Expected o_lmfc: with F=1,K=3 the multiframe is 8 cycles long starting at release of reset.
    task automatic run_vec(input int idx, input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            i_link_en = v.en;
            i_sync_n  = v.sn;
            i_seq_end = v.se;
            @(negedge clk);
            check($sformatf("row%0d", idx),
                  {v.st, v.lu, (cyc % 8 == 0), v.ss, v.sr, v.er, v.nf});
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t post;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst_n        = 1'b0;
        i_link_en    = 1'b0;
        i_sync_n     = 1'b1;
        i_seq_end    = 1'b0;
        i_F          = 8'd1;
        i_K          = 5'd3;

        //   n  en sn se  st  lu ss sr er nf
        add(8,  0, 1, 0, 2'd0, 0, 0, 0, 0, 5'd0);  // idle after reset
        add(20, 1, 0, 0, 2'd0, 0, 0, 0, 0, 5'd0);  // enable, SYNC~ low 20 cycles
        add(1,  1, 1, 0, 2'd0, 0, 0, 0, 0, 5'd0);  // release at frame 2
        add(2,  1, 1, 0, 2'd0, 0, 0, 0, 0, 5'd2);  // wait for LMFC
        add(1,  1, 1, 0, 2'd0, 0, 1, 0, 0, 5'd2);  // octet 1 / frame 3: ILA start
        add(1,  1, 1, 0, 2'd1, 0, 0, 0, 0, 5'd2);  // ILA entered
        add(1,  1, 1, 1, 2'd1, 0, 0, 0, 0, 5'd2);  // ILA end
        add(2,  1, 1, 0, 2'd2, 1, 0, 0, 0, 5'd2);  // DATA
        add(4,  1, 0, 0, 2'd2, 1, 0, 0, 0, 5'd2);  // short low, 4 cycles
        add(1,  1, 1, 0, 2'd2, 1, 0, 0, 1, 5'd2);  // error report
        add(1,  1, 1, 0, 2'd2, 1, 0, 0, 0, 5'd2);
        add(18, 1, 0, 0, 2'd2, 1, 0, 0, 0, 5'd2);  // low T-1 cycles
        add(1,  1, 1, 0, 2'd2, 1, 0, 0, 1, 5'd2);  // still only an error report
        add(18, 1, 0, 0, 2'd2, 1, 0, 0, 0, 5'd2);  // low 18 ...
        add(1,  1, 0, 0, 2'd2, 1, 0, 1, 0, 5'd2);  // ... 19th low cycle: resync
        add(2,  1, 0, 0, 2'd0, 0, 0, 0, 0, 5'd2);  // back in CGS
        add(1,  1, 1, 0, 2'd0, 0, 0, 0, 0, 5'd2);  // release at frame 1
        add(4,  1, 1, 0, 2'd0, 0, 0, 0, 0, 5'd1);
        add(1,  1, 1, 0, 2'd0, 0, 1, 0, 0, 5'd1);  // ILA start
        add(1,  1, 0, 1, 2'd1, 0, 0, 0, 0, 5'd1);  // SYNC~ low together with ILA end
        add(1,  1, 0, 0, 2'd0, 0, 0, 0, 0, 5'd1);  // CGS, not DATA
        add(1,  1, 1, 0, 2'd0, 0, 0, 0, 0, 5'd1);  // release at frame 1
        add(4,  1, 1, 0, 2'd0, 0, 0, 0, 0, 5'd1);  // WAIT_LMFC
        add(1,  0, 1, 0, 2'd0, 0, 0, 0, 0, 5'd1);  // disable on LMFC boundary: no start
        add(1,  1, 0, 0, 2'd0, 0, 0, 0, 0, 5'd1);  // IDLE, re-enable
        add(1,  1, 0, 0, 2'd0, 0, 0, 0, 0, 5'd1);  // CGS
        add(1,  1, 1, 0, 2'd0, 0, 0, 0, 0, 5'd1);  // release at frame 1
        add(4,  1, 1, 0, 2'd0, 0, 0, 0, 0, 5'd1);
        add(1,  1, 1, 0, 2'd0, 0, 1, 0, 0, 5'd1);  // ILA start
        add(1,  1, 1, 0, 2'd1, 0, 0, 0, 0, 5'd1);  // ILA

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", 12'b00_0_1_0_0_0_00000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;

        for (int r = 0; r < vecs.size(); r++) begin
            run_vec(r, vecs[r]);
        end

        // Still in ILA here; reset must take effect without a clock edge.
        i_link_en = 1'b1;
        i_sync_n  = 1'b1;
        i_seq_end = 1'b0;
        #1;
        tests_run++;
        if (o_state !== 2'b01) begin
            tests_failed++;
            $display("FAIL pre_reset_ila state got %b want 01", o_state);
        end
        rst_n = 1'b0;
        #1;
        check("async_reset", 12'b00_0_1_0_0_0_00000);
        i_link_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        post.n = 10; post.en = 1'b0; post.sn = 1'b1; post.se = 1'b0; post.st = 2'd0;
        post.lu = 1'b0; post.ss = 1'b0; post.sr = 1'b0; post.er = 1'b0; post.nf = 5'd0;
        run_vec(99, post);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog: the stimulus is fixed length, this only guards against a stuck run.
    initial begin
        #20000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
